// File: rtl/sp_step_sequencer.sv
// sp_step_sequencer: arbitrates two stack requesters (A = pipeline, B = interrupt/call
// unit) and steps the SP incrementer one word per cycle, checking SP bounds before each step.
// Optional build macro: SP_SEQ_ROUND_ROBIN_EN (round-robin arbitration; otherwise B has fixed priority).
//
// state | meaning
// IDLE  | waiting for a request
// STEP  | issuing one SP step per cycle for the owner
// DONE  | one-cycle completion pulse for the owner, Err reports a bound abort
module sp_step_sequencer #(
  parameter logic [15:0] STACK_BASE  = 16'hFFFF,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        ReqA,
  input  logic        OpA,
  input  logic [1:0]  CountA,
  input  logic        ReqB,
  input  logic        OpB,
  input  logic [1:0]  CountB,
  output logic        GntA,
  output logic        GntB,
  output logic        DoneA,
  output logic        DoneB,
  output logic        Err,
  output logic        Busy,
  input  logic [15:0] SpIn,
  output logic        SpWrite,
  output logic        SpOp
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;       // 0 = A, 1 = B
  logic       op_q, op_d;             // 1 = push
  logic [1:0] remaining_q, remaining_d;
  logic       err_q, err_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
`ifdef SP_SEQ_ROUND_ROBIN_EN
  logic       rr_q, rr_d;             // 1 = B has priority on the next tie
`endif

  logic       win_b;
  logic       win_op;
  logic [1:0] win_cnt;
  logic       bound_hit;

  // Arbitration between the requesters and the bound check against the live SP
  always_comb begin
`ifdef SP_SEQ_ROUND_ROBIN_EN
    win_b = ReqB & (~ReqA | rr_q);
`else
    win_b = ReqB;
`endif
    win_op    = win_b ? OpB : OpA;
    win_cnt   = win_b ? CountB : CountA;
    bound_hit = op_q ? (SpIn == STACK_LIMIT) : (SpIn == STACK_BASE);
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      op_q        <= 1'b0;
      remaining_q <= 2'd0;
      err_q       <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
`ifdef SP_SEQ_ROUND_ROBIN_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
`ifdef SP_SEQ_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

  // Next-state logic: accept, step with bound abort, completion
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
`ifdef SP_SEQ_ROUND_ROBIN_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ReqA | ReqB) begin
          owner_d     = win_b;
          op_d        = win_op;
          remaining_d = win_cnt;
          err_d       = 1'b0;
          gnt_a_d     = ~win_b;
          gnt_b_d     = win_b;
`ifdef SP_SEQ_ROUND_ROBIN_EN
          rr_d        = ~win_b;
`endif
          state_d     = (win_cnt == 2'd0) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        if (bound_hit) begin
          // abandon the unfinished steps; SP stays at the bound
          err_d       = 1'b1;
          remaining_d = 2'd0;
          state_d     = S_DONE;
        end else begin
          remaining_d = remaining_q - 2'd1;
          if (remaining_q == 2'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; the step is suppressed during Reset so an aborted operation writes nothing more
  always_comb begin
    Busy    = (state_q != S_IDLE);
    SpWrite = (state_q == S_STEP) & ~bound_hit & ~Reset;
    SpOp    = SpWrite & op_q;
    GntA    = gnt_a_q;
    GntB    = gnt_b_q;
    DoneA   = (state_q == S_DONE) & ~owner_q;
    DoneB   = (state_q == S_DONE) & owner_q;
    Err     = (state_q == S_DONE) & err_q;
  end

endmodule

// File: tb/tb_sp_step_sequencer.sv
// Testbench for sp_step_sequencer: SP register model plus a scoreboard of expected completions.
module tb_sp_step_sequencer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqA = 1'b0, OpA = 1'b0, ReqB = 1'b0, OpB = 1'b0;
  logic [1:0]  CountA = 2'd0, CountB = 2'd0;
  logic        GntA, GntB, DoneA, DoneB, Err, Busy, SpWrite, SpOp;
  logic [15:0] sp_q = 16'hFFFF;
  logic        sp_load = 1'b0;
  logic [15:0] sp_load_val = 16'h0000;

  typedef struct {
    logic        owner;
    logic        op;
    logic        err;
    logic [15:0] sp;
    int          writes;
    int          busy;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;
  int   busy_cnt = 0;

  sp_step_sequencer dut (
    .CLK(CLK), .Reset(Reset),
    .ReqA(ReqA), .OpA(OpA), .CountA(CountA),
    .ReqB(ReqB), .OpB(OpB), .CountB(CountB),
    .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
    .Err(Err), .Busy(Busy), .SpIn(sp_q), .SpWrite(SpWrite), .SpOp(SpOp)
  );

  always #5 CLK = ~CLK;

  // SP incrementer model: Op 0 = +1, 1 = -1, wraps mod 2^16
  always @(posedge CLK) begin
    if (sp_load) sp_q <= sp_load_val;
    else if (SpWrite) sp_q <= SpOp ? sp_q - 16'd1 : sp_q + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Monitor: count writes/busy cycles, compare against the scoreboard on every Done
  always @(negedge CLK) begin
    if (Reset) begin
      wr_cnt   = 0;
      busy_cnt = 0;
    end else begin
      if (SpWrite) begin
        wr_cnt++;
        if (sb.size() > 0) chk("spop", 32'(SpOp), 32'(sb[0].op));
      end
      if (Busy) busy_cnt++;
      if (DoneA | DoneB) begin
        if (sb.size() == 0) chk("unexpected_done", 32'({DoneA, DoneB}), 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_owner", 32'({DoneA, DoneB}), 32'({~e.owner, e.owner}));
          chk("err", 32'(Err), 32'(e.err));
          chk("final_sp", 32'(sp_q), 32'(e.sp));
          chk("writes", 32'(wr_cnt), 32'(e.writes));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
        end
        wr_cnt   = 0;
        busy_cnt = 0;
        done_cnt++;
      end else begin
        chk("err_idle", 32'(Err), 32'd0);
      end
    end
  end

  task automatic load_sp(input logic [15:0] v);
    @(posedge CLK); #1;
    sp_load = 1'b1; sp_load_val = v;
    @(posedge CLK); #1;
    sp_load = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < 20) begin
      @(posedge CLK); #1;
      if (GntA) ReqA = 1'b0;
      if (GntB) ReqB = 1'b0;
      n++;
    end
    if (done_cnt < target) chk({tag, "_timeout"}, 32'(done_cnt), 32'(target));
    @(posedge CLK); #1;
  endtask

  task automatic run_single(input string tag, input logic b, input logic op, input logic [1:0] cnt,
                            input logic [15:0] start, input logic err, input logic [15:0] fsp,
                            input int wr, input int bsy);
    exp_t e;
    int   target;
    load_sp(start);
    e.owner = b; e.op = op; e.err = err; e.sp = fsp; e.writes = wr; e.busy = bsy;
    sb.push_back(e);
    target = done_cnt + 1;
    if (b) begin ReqB = 1'b1; OpB = op; CountB = cnt; end
    else   begin ReqA = 1'b1; OpA = op; CountA = cnt; end
    @(posedge CLK); #1;
    chk({tag, "_gnt_own"}, 32'(b ? GntB : GntA), 32'd1);
    chk({tag, "_gnt_other"}, 32'(b ? GntA : GntB), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd1);
    ReqA = 1'b0; ReqB = 1'b0;
    wait_done(target, tag);
    chk({tag, "_idle_after"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   target;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", 32'({GntA, GntB, DoneA, DoneB, Err, Busy, SpWrite, SpOp}), 32'd0);
    Reset = 1'b0;
    @(posedge CLK); #1;
    chk("idle_outs", 32'({GntA, GntB, DoneA, DoneB, Err, Busy, SpWrite, SpOp}), 32'd0);

    // Simultaneous 1-word pushes straight after reset
    load_sp(16'hFFFF);
    e.op = 1'b1; e.err = 1'b0; e.writes = 1; e.busy = 2;
`ifdef SP_SEQ_ROUND_ROBIN_EN
    e.owner = 1'b0; e.sp = 16'hFFFE; sb.push_back(e);
    e.owner = 1'b1; e.sp = 16'hFFFD; sb.push_back(e);
`else
    e.owner = 1'b1; e.sp = 16'hFFFE; sb.push_back(e);
    e.owner = 1'b0; e.sp = 16'hFFFD; sb.push_back(e);
`endif
    target = done_cnt + 2;
    ReqA = 1'b1; OpA = 1'b1; CountA = 2'd1;
    ReqB = 1'b1; OpB = 1'b1; CountB = 2'd1;
    wait_done(target, "simul");
    chk("simul_sp", 32'(sp_q), 32'h0000FFFD);

    //          tag         B     op    cnt   start     err   final     wr bsy
    run_single("push3",    1'b0, 1'b1, 2'd3, 16'hFFFF, 1'b0, 16'hFFFC, 3, 4);
    run_single("pop2",     1'b1, 1'b0, 2'd2, 16'hFFFC, 1'b0, 16'hFFFE, 2, 3);
    run_single("overflow", 1'b0, 1'b1, 2'd3, 16'hFF01, 1'b1, 16'hFF00, 1, 3);
    run_single("underflw", 1'b1, 1'b0, 2'd1, 16'hFFFF, 1'b1, 16'hFFFF, 0, 2);
    run_single("zerocnt",  1'b0, 1'b1, 2'd0, 16'hFFF0, 1'b0, 16'hFFF0, 0, 1);
    run_single("pop_wrap", 1'b0, 1'b0, 2'd3, 16'hFF80, 1'b0, 16'hFF83, 3, 4);

    // Reset during the second STEP cycle of a 3-word push
    load_sp(16'hFFFF);
    target = done_cnt;
    ReqA = 1'b1; OpA = 1'b1; CountA = 2'd3;
    @(posedge CLK); #1;
    chk("rst_gnt", 32'(GntA), 32'd1);
    ReqA = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    chk("rst_outs", 32'({GntA, GntB, DoneA, DoneB, Err, Busy, SpWrite, SpOp}), 32'd0);
    chk("rst_sp", 32'(sp_q), 32'h0000FFFE);
    Reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_no_done", 32'(done_cnt), 32'(target));
    chk("rst_idle", 32'(Busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sp_step_sequencer.md
# sp_step_sequencer

Sequences the stage-1 stack-pointer incrementer on behalf of two requesters: the pipeline (A) and the interrupt/call unit (B). Each accepted request is a push or pop of 0–3 words. The block drives the incrementer's write-enable and op (one step per cycle) and checks the live SP against stack bounds before every step. It sits between the control unit and the SP incrementer and is the only driver of that incrementer's RegWrite/Op.

## Interface
Parameters:
- STACK_BASE, 16'hFFFF, SP value when the stack is empty; a pop at this value is an underflow.
- STACK_LIMIT, 16'hFF00, lowest legal SP; a push at this value is an overflow.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReqA  in  1  requester A request; held until GntA.
- OpA  in  1  1 = push (SP decrements), 0 = pop (SP increments).
- CountA  in  2  words to move, 0–3.
- ReqB, OpB, CountB  in  1/1/2  same meaning for requester B.
- GntA, GntB  out  1  one-cycle accept pulse.
- DoneA, DoneB  out  1  one-cycle completion pulse.
- Err  out  1  high with Done when the operation aborted on a bound.
- Busy  out  1  high whenever state ≠ IDLE.
- SpIn  in  16  current SP (incrementer RegOut).
- SpWrite  out  1  incrementer RegWrite.
- SpOp  out  1  incrementer Op: 0 = +1, 1 = −1.

## Operation
- FSM states: IDLE, STEP, DONE.
- IDLE → STEP: at least one Req high at the edge and Count ≠ 0.
  - Winner is chosen by arbitration (see Configuration).
  - Op and Count are latched into owner, op_q and remaining (2-bit).
- IDLE → DONE: winner's Count = 0. No SpWrite is issued.
- STEP with no bound hit:
  - SpWrite = 1, SpOp = op_q. SpWrite is combinational from state, op_q and SpIn.
  - remaining decrements.
  - When remaining = 1 at the edge, go to DONE; otherwise stay in STEP.
- STEP with a bound hit (op_q = 1 and SpIn == STACK_LIMIT, or op_q = 0 and SpIn == STACK_BASE):
  - SpWrite = 0.
  - err_q is set; unfinished steps are abandoned; go to DONE.
- DONE: Done for the owner = 1, Err = err_q. Go to IDLE next cycle and clear err_q.
- Gnt for the owner is a registered pulse in the first cycle after the accept edge, i.e. the first STEP or DONE cycle.
- A requester must drop Req in the Gnt cycle or earlier. A Req still high in IDLE after DONE is a new request.
- The losing requester keeps Req high and is served after the current owner's DONE. No Gnt is issued while Busy.
- SP arithmetic wraps mod 2^16 in the incrementer. The bound checks prevent stepping past STACK_LIMIT or STACK_BASE.

## Timing
- Reset values: state IDLE; remaining 0; err_q 0; all outputs 0. Round-robin pointer: A has priority next.
- Reset mid-operation: the next cycle is IDLE with all outputs 0.
  - No Done is issued for the aborted owner.
  - SP steps already written are not undone.
- Latency, N-word request (N = 1–3), no error: accept edge → N STEP cycles (SpWrite high in each) → 1 DONE cycle. Busy lasts N+1 cycles.
- Count = 0: accept edge → DONE cycle. Busy lasts 1 cycle.
- SpIn reflects each write one edge later. Every bound check therefore sees the already-updated SP.
- Back-to-back: IDLE occupies at least one cycle between operations. Maximum throughput is one operation per N+2 cycles.

## Configuration
- SP_SEQ_ROUND_ROBIN_EN defined: round-robin arbitration.
  - When both Req are high in IDLE, the requester not served last wins.
  - The pointer updates on every accept.
- SP_SEQ_ROUND_ROBIN_EN undefined: fixed priority; B always wins simultaneous requests.
- Single-requester behaviour is identical in both builds.

## Test plan
Bench models the SP register with the incrementer semantics and defaults STACK_BASE = FFFF, STACK_LIMIT = FF00.
- Push, no error: SP = FFFF; ReqA, OpA = 1, CountA = 3 → GntA 1 cycle; SpWrite/SpOp = 1 for 3 cycles; SP = FFFC; DoneA = 1, Err = 0; Busy for 4 cycles.
- Pop, no error: SP = FFFC; ReqB, OpB = 0, CountB = 2 → 2 writes with SpOp = 0; SP = FFFE; DoneB = 1, Err = 0.
- Simultaneous requests after reset, ReqA and ReqB both 1-word pushes:
  - Macro defined: A is served first, then B. SP = FFFF → FFFE → FFFD.
  - Macro undefined: B is served first.
- Overflow: SP = FF01; push 3 from A → one write (SP = FF00); next cycle SpWrite = 0; DoneA = 1, Err = 1; final SP = FF00.
- Underflow and zero count:
  - SP = FFFF; pop 1 from B → no SpWrite; DoneB and Err in the cycle after accept.
  - CountA = 0 → GntA and DoneA in the same cycle; Err = 0.
- Reset mid-operation: SP = FFFF; push 3 from A; Reset high during the 2nd STEP cycle → all outputs 0 next cycle; no DoneA; SP = FFFE.
